lms_fir_engine: RTL



---
 rtl/lms_fir_engine.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/lms_fir_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lms_fir_engine                                               |
// | Description : Adaptive FIR with sign-exact (delayed) LMS weight update,    |
// |               LANES taps per cycle, two-stage MAC output pipeline.         |
// |               Optional leaky update when LMS_LEAK_EN is defined.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lms_fir_engine #(
    parameter int DATA_W     = 16,
    parameter int COEF_W     = 24,
    parameter int TAPS       = 128,
    parameter int LANES      = 2,
    parameter int FRAC       = 15,
    parameter int LEAK_SHIFT = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] err_in,
    input  logic [3:0]        mu_shift,
    input  logic              adapt_en,
    input  logic              coef_clr,
    output logic              busy,
    output logic [DATA_W-1:0] y_out,
    output logic              y_valid,
    output logic              done
);

    localparam int G      = TAPS / LANES;
    localparam int GW     = (G > 1) ? $clog2(G) : 1;
    localparam int TW     = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int PSUM_W = PROD_W + $clog2(LANES) + 1;
    localparam int EX_W   = 2 * DATA_W;
    localparam int UPD_W  = ((COEF_W > EX_W) ? COEF_W : EX_W) + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [GW-1:0]              grp_q, grp_d;
    logic                       drain_q, drain_d;
    logic signed [DATA_W-1:0]   x_q   [TAPS];
    logic signed [COEF_W-1:0]   w_q   [TAPS];
    logic signed [DATA_W-1:0]   err_q;
    logic [3:0]                 mu_q;
    logic                       adapt_q;
    logic signed [PROD_W-1:0]   prod_q [LANES];
    logic                       pv_q;
    logic signed [ACC_W-1:0]    acc_q;
    logic [DATA_W-1:0]          y_q;

    logic signed [DATA_W-1:0]   lx     [LANES];
    logic signed [COEF_W-1:0]   lw     [LANES];
    logic signed [COEF_W-1:0]   lw_new [LANES];
    logic signed [PROD_W-1:0]   lprod  [LANES];
    logic signed [PSUM_W-1:0]   psum, psum_sh;
    logic [5:0]                 shamt;
    logic                       accept;

    function automatic logic signed [COEF_W-1:0] sat_coef(input logic signed [UPD_W-1:0] v);
        if ((v[UPD_W-1:COEF_W-1] == '0) || (v[UPD_W-1:COEF_W-1] == '1))
            return v[COEF_W-1:0];
        else if (v[UPD_W-1])
            return {1'b1, {(COEF_W-1){1'b0}}};
        else
            return {1'b0, {(COEF_W-1){1'b1}}};
    endfunction

    function automatic logic [DATA_W-1:0] sat_data(input logic signed [ACC_W-1:0] v);
        if ((v[ACC_W-1:DATA_W-1] == '0) || (v[ACC_W-1:DATA_W-1] == '1))
            return v[DATA_W-1:0];
        else if (v[ACC_W-1])
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

    // A clear request in IDLE takes priority over a simultaneous start.
    assign accept = (state_q == S_IDLE) && start && !coef_clr;
    assign shamt  = 6'(FRAC) + {2'b00, mu_q};

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        drain_d = drain_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_RUN;
                    grp_d   = '0;
                end
            end
            S_RUN: begin
                if (grp_q == GW'(G - 1)) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    grp_d = grp_q + GW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q)
                    state_d = S_DONE;
                else
                    drain_d = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [TW-1:0]            idx;
        logic signed [EX_W-1:0]   ex;
        logic signed [EX_W-1:0]   delta;
        logic signed [UPD_W-1:0]  upd;

        assign idx      = TW'(grp_q) * TW'(LANES) + TW'(l);
        assign lx[l]    = x_q[idx];
        assign lw[l]    = w_q[idx];
        assign lprod[l] = PROD_W'(lw[l]) * PROD_W'(lx[l]);
        assign ex       = EX_W'(err_q) * EX_W'(lx[l]);
        assign delta    = ex >>> shamt;
`ifdef LMS_LEAK_EN
        assign upd      = UPD_W'(lw[l]) - UPD_W'(lw[l] >>> LEAK_SHIFT) + UPD_W'(delta);
`else
        assign upd      = UPD_W'(lw[l]) + UPD_W'(delta);
`endif
        assign lw_new[l] = sat_coef(upd);
    end

    always_comb begin
        psum = '0;
        for (int l = 0; l < LANES; l++) begin
            psum = psum + PSUM_W'(prod_q[l]);
        end
    end

    assign psum_sh = psum >>> FRAC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            grp_q   <= '0;
            drain_q <= 1'b0;
            err_q   <= '0;
            mu_q    <= '0;
            adapt_q <= 1'b0;
            pv_q    <= 1'b0;
            acc_q   <= '0;
            y_q     <= '0;
            for (int l = 0; l < LANES; l++) begin
                prod_q[l] <= '0;
            end
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            drain_q <= drain_d;
            if (accept) begin
                err_q   <= err_in;
                mu_q    <= mu_shift;
                adapt_q <= adapt_en;
            end
            pv_q <= (state_q == S_RUN);
            for (int l = 0; l < LANES; l++) begin
                prod_q[l] <= lprod[l];
            end
            if (accept)
                acc_q <= '0;
            else if (pv_q)
                acc_q <= acc_q + ACC_W'(psum_sh);
            // Accumulator is final after the first drain cycle.
            if ((state_q == S_DRAIN) && drain_q)
                y_q <= sat_data(acc_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
            end
        end else if (accept) begin
            x_q[0] <= x_in;
            for (int i = 1; i < TAPS; i++) begin
                x_q[i] <= x_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                w_q[i] <= '0;
            end
        end else if ((state_q == S_IDLE) && coef_clr) begin
            for (int i = 0; i < TAPS; i++) begin
                w_q[i] <= '0;
            end
        end else if ((state_q == S_RUN) && adapt_q) begin
            for (int i = 0; i < TAPS; i++) begin
                if ((i / LANES) == int'(grp_q))
                    w_q[i] <= lw_new[i % LANES];
            end
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign y_valid = (state_q == S_DONE);
    assign y_out   = y_q;

endmodule
`default_nettype wire
